// File: rtl/rtc_bus_arbiter.sv
// RTC multiplexed-bus arbiter: round-robin between write and read requesters,
// runs each grant as a fixed address/data phase sequence of STEP clocks per phase.
module rtc_bus_arbiter #(
    parameter int STEP = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       w_req,
    input  logic [7:0] w_addr,
    input  logic [7:0] w_data,
    output logic       w_gnt,
    output logic       w_done,
    input  logic       r_req,
    input  logic [7:0] r_addr,
    output logic [7:0] r_data,
    output logic       r_gnt,
    output logic       r_done,
    output logic       busy,
    output logic       ad,
    output logic       cs,
    output logic       wr,
    output logic       rd,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    typedef enum logic [3:0] {
        IDLE, A_SETUP, A_STROBE, A_HOLD, GAP,
        D_SETUP, D_STROBE, D_HOLD, RECOVER, DONE
    } state_t;

    localparam logic [7:0] LAST = 8'(STEP - 1);

    state_t     state, nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       dir_w, nxt_w;
    logic [7:0] addr, nxt_addr;
    logic [7:0] wdata, nxt_wdata;
    logic       last_w, nxt_last;
    logic       gw, gr, phase_end, capture;
    logic       p_ad, p_cs, p_wr, p_rd, p_oe;
    logic [7:0] p_out;

    assign phase_end = (cnt == LAST);
    assign capture   = (state == D_STROBE) && phase_end && !dir_w;

    always_comb begin
        nxt       = state;
        cnt_nxt   = cnt;
        nxt_w     = dir_w;
        nxt_addr  = addr;
        nxt_wdata = wdata;
        nxt_last  = last_w;
        gw        = 1'b0;
        gr        = 1'b0;
        unique case (state)
            IDLE: begin
                // On a tie the port that did not win last time is served
                if (w_req && (!r_req || !last_w)) gw = 1'b1;
                else if (r_req)                   gr = 1'b1;
                if (gw || gr) begin
                    nxt       = A_SETUP;
                    cnt_nxt   = 8'd0;
                    nxt_w     = gw;
                    nxt_addr  = gw ? w_addr : r_addr;
                    nxt_wdata = w_data;
                    nxt_last  = gw;
                end
            end
            DONE: nxt = IDLE;
            default: begin
                if (phase_end) begin
                    nxt     = state_t'(state + 4'd1);
                    cnt_nxt = 8'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
        endcase
    end

    // Pins are decoded from the next state so they come straight off flops
    always_comb begin
        p_ad  = 1'b1;
        p_cs  = 1'b1;
        p_wr  = 1'b1;
        p_rd  = 1'b1;
        p_oe  = 1'b0;
        p_out = 8'd0;
        unique case (nxt)
            A_SETUP: begin
                p_ad  = 1'b0;
                p_cs  = 1'b0;
                p_oe  = 1'b1;
                p_out = nxt_addr;
            end
            A_STROBE: begin
                p_ad  = 1'b0;
                p_cs  = 1'b0;
                p_wr  = 1'b0;
                p_oe  = 1'b1;
                p_out = nxt_addr;
            end
            A_HOLD: begin
                p_ad  = 1'b0;
                p_oe  = 1'b1;
                p_out = nxt_addr;
            end
            D_SETUP, D_HOLD: begin
                p_cs  = 1'b0;
                p_oe  = nxt_w;
                p_out = nxt_w ? nxt_wdata : 8'd0;
            end
            D_STROBE: begin
                p_cs  = 1'b0;
                p_wr  = !nxt_w;
                p_rd  = nxt_w;
                p_oe  = nxt_w;
                p_out = nxt_w ? nxt_wdata : 8'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            dir_w  <= 1'b0;
            addr   <= 8'd0;
            wdata  <= 8'd0;
            last_w <= 1'b0;
            ad     <= 1'b1;
            cs     <= 1'b1;
            wr     <= 1'b1;
            rd     <= 1'b1;
            ad_oe  <= 1'b0;
            ad_out <= 8'd0;
            r_data <= 8'd0;
            w_gnt  <= 1'b0;
            r_gnt  <= 1'b0;
            w_done <= 1'b0;
            r_done <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= nxt;
            cnt    <= cnt_nxt;
            dir_w  <= nxt_w;
            addr   <= nxt_addr;
            wdata  <= nxt_wdata;
            last_w <= nxt_last;
            ad     <= p_ad;
            cs     <= p_cs;
            wr     <= p_wr;
            rd     <= p_rd;
            ad_oe  <= p_oe;
            ad_out <= p_out;
            w_gnt  <= gw;
            r_gnt  <= gr;
            w_done <= (nxt == DONE) && nxt_w;
            r_done <= (nxt == DONE) && !nxt_w;
            busy   <= (nxt != IDLE);
            if (capture) r_data <= ad_in;
        end
    end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Randomized bench for rtc_bus_arbiter: two instances (STEP=4, STEP=1)
// checked cycle by cycle against a phase-table model of the bus sequence.
module tb_rtc_bus_arbiter;

    localparam int S0 = 4;
    localparam int S1 = 1;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset  [2];
    logic       w_req  [2];
    logic [7:0] w_addr [2];
    logic [7:0] w_data [2];
    logic       w_gnt  [2];
    logic       w_done [2];
    logic       r_req  [2];
    logic [7:0] r_addr [2];
    logic [7:0] r_data [2];
    logic       r_gnt  [2];
    logic       r_done [2];
    logic       busy   [2];
    logic       ad     [2];
    logic       cs     [2];
    logic       wr     [2];
    logic       rd     [2];
    logic [7:0] ad_out [2];
    logic       ad_oe  [2];
    logic [7:0] ad_in  [2];

    rtc_bus_arbiter #(.STEP(S0)) u0 (
        .clock(clock), .reset(reset[0]),
        .w_req(w_req[0]), .w_addr(w_addr[0]), .w_data(w_data[0]),
        .w_gnt(w_gnt[0]), .w_done(w_done[0]),
        .r_req(r_req[0]), .r_addr(r_addr[0]), .r_data(r_data[0]),
        .r_gnt(r_gnt[0]), .r_done(r_done[0]), .busy(busy[0]),
        .ad(ad[0]), .cs(cs[0]), .wr(wr[0]), .rd(rd[0]),
        .ad_out(ad_out[0]), .ad_oe(ad_oe[0]), .ad_in(ad_in[0])
    );

    rtc_bus_arbiter #(.STEP(S1)) u1 (
        .clock(clock), .reset(reset[1]),
        .w_req(w_req[1]), .w_addr(w_addr[1]), .w_data(w_data[1]),
        .w_gnt(w_gnt[1]), .w_done(w_done[1]),
        .r_req(r_req[1]), .r_addr(r_addr[1]), .r_data(r_data[1]),
        .r_gnt(r_gnt[1]), .r_done(r_done[1]), .busy(busy[1]),
        .ad(ad[1]), .cs(cs[1]), .wr(wr[1]), .rd(rd[1]),
        .ad_out(ad_out[1]), .ad_oe(ad_oe[1]), .ad_in(ad_in[1])
    );

    typedef struct packed {
        logic       ad, cs, wr, rd, oe;
        logic [7:0] dout;
        logic       busy, wg, rg, wd, rdn;
    } pins_t;

    int         vectors = 0;
    int         miscompares = 0;
    int         steps [2];
    bit         last_w [2];
    logic [7:0] exp_rdata [2];

    function automatic pins_t observe(int d);
        pins_t p;
        p.ad = ad[d]; p.cs = cs[d]; p.wr = wr[d]; p.rd = rd[d];
        p.oe = ad_oe[d]; p.dout = ad_out[d]; p.busy = busy[d];
        p.wg = w_gnt[d]; p.rg = r_gnt[d]; p.wd = w_done[d]; p.rdn = r_done[d];
        return p;
    endfunction

    function automatic pins_t idle_pins();
        pins_t p;
        p = '0;
        p.ad = 1'b1; p.cs = 1'b1; p.wr = 1'b1; p.rd = 1'b1;
        return p;
    endfunction

    // Expected pins i cycles after the IDLE cycle that saw the request
    function automatic pins_t model(int i, int step, bit is_w,
                                    logic [7:0] a, logic [7:0] dt);
        pins_t p;
        int    ph;
        p = idle_pins();
        p.busy = 1'b1;
        if (i == 8 * step + 1) begin
            p.wd  = is_w;
            p.rdn = !is_w;
            return p;
        end
        ph = (i - 1) / step;
        p.wg = is_w && (i == 1);
        p.rg = !is_w && (i == 1);
        if (ph <= 2) begin
            p.ad = 1'b0; p.oe = 1'b1; p.dout = a;
            p.cs = (ph == 2);
            p.wr = (ph != 1);
        end else if (ph >= 4 && ph <= 6) begin
            p.cs = 1'b0; p.oe = is_w; p.dout = is_w ? dt : 8'd0;
            if (ph == 5) begin
                if (is_w) p.wr = 1'b0;
                else      p.rd = 1'b0;
            end
        end
        return p;
    endfunction

    // Runs one arbitration + transaction starting from an IDLE negedge
    task automatic run_txn(input int d, input int abort_i, input bit drop_mid,
                           input bit hold, input string tag);
        int         step, n;
        bit         is_w;
        logic [7:0] a, dt, rv;
        pins_t      e, o;
        step = steps[d];
        n    = 8 * step + 1;
        is_w = w_req[d] && (!r_req[d] || !last_w[d]);
        a    = is_w ? w_addr[d] : r_addr[d];
        dt   = w_data[d];
        rv   = 8'($urandom);
        last_w[d] = is_w;
        for (int i = 1; i <= n; i++) begin
            @(negedge clock);
            e = model(i, step, is_w, a, dt);
            o = observe(d);
            if (!e.oe) begin
                e.dout = 8'd0;
                o.dout = 8'd0;
            end
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL %s cyc%0d: pins got %h expected %h", tag, i, o, e);
            end
            if (i == abort_i) begin
                reset[d] = 1'b1;
                return;
            end
            w_addr[d] = 8'($urandom);
            w_data[d] = 8'($urandom);
            r_addr[d] = 8'($urandom);
            ad_in[d]  = (i == 6 * step && !is_w) ? rv : ~rv;
            if (drop_mid && i == 2) begin
                if (is_w) w_req[d] = 1'b0;
                else      r_req[d] = 1'b0;
            end
            if (i == n) begin
                if (!is_w) exp_rdata[d] = rv;
                vectors++;
                if (r_data[d] !== exp_rdata[d]) begin
                    miscompares++;
                    $display("FAIL %s r_data: got %h expected %h", tag, r_data[d], exp_rdata[d]);
                end
                if (!hold) begin
                    if (is_w) w_req[d] = 1'b0;
                    else      r_req[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic idle_cycle(input int d, input string tag);
        pins_t e, o;
        @(negedge clock);
        e = idle_pins();
        o = observe(d);
        o.dout = 8'd0;
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL %s idle: pins got %h expected %h", tag, o, e);
        end
    endtask

    task automatic test_reset();
        pins_t e, o;
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; w_req[d] = 1'b0; r_req[d] = 1'b0;
            w_addr[d] = 8'd0; w_data[d] = 8'd0; r_addr[d] = 8'd0; ad_in[d] = 8'd0;
        end
        repeat (2) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            e = idle_pins();
            o = observe(d);
            vectors++;
            if (o !== e || r_data[d] !== 8'd0) begin
                miscompares++;
                $display("FAIL reset%0d: pins %h rdata %h expected %h rdata 00", d, o, r_data[d], e);
            end
            reset[d] = 1'b0;
            last_w[d] = 1'b0;
            exp_rdata[d] = 8'd0;
        end
    endtask

    task automatic test_single_write();
        w_req[0] = 1'b1; w_addr[0] = 8'h21; w_data[0] = 8'h45;
        run_txn(0, 0, 1'b0, 1'b0, "single_write");
        idle_cycle(0, "single_write");
    endtask

    task automatic test_single_read();
        r_req[0] = 1'b1; r_addr[0] = 8'h26;
        run_txn(0, 0, 1'b0, 1'b0, "single_read");
        idle_cycle(0, "single_read");
    endtask

    task automatic test_back_to_back();
        reset[0] = 1'b1;
        @(negedge clock);
        reset[0] = 1'b0;
        last_w[0] = 1'b0;
        exp_rdata[0] = 8'd0;
        w_req[0] = 1'b1; r_req[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_txn(0, 0, 1'b0, (k != 3), "back_to_back");
            if (k == 3) r_req[0] = 1'b0;
            idle_cycle(0, "back_to_back");
        end
        w_req[0] = 1'b0; r_req[0] = 1'b0;
    endtask

    task automatic test_input_change();
        w_req[0] = 1'b1; w_addr[0] = 8'h21; w_data[0] = 8'h45;
        run_txn(0, 0, 1'b0, 1'b0, "input_change");
        idle_cycle(0, "input_change");
    endtask

    task automatic test_req_drop();
        r_req[0] = 1'b1; r_addr[0] = 8'h30;
        run_txn(0, 0, 1'b1, 1'b0, "req_drop");
        idle_cycle(0, "req_drop");
    endtask

    task automatic test_reset_mid();
        w_req[0] = 1'b1; r_req[0] = 1'b0; w_addr[0] = 8'h12; w_data[0] = 8'h34;
        run_txn(0, 5 * S0 + 2, 1'b0, 1'b0, "reset_mid");
        w_req[0] = 1'b0;
        r_req[0] = 1'b1;
        r_addr[0] = 8'h26;
        idle_cycle(0, "reset_mid");
        vectors++;
        if (r_data[0] !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_mid r_data: got %h expected 00", r_data[0]);
        end
        reset[0] = 1'b0;
        last_w[0] = 1'b0;
        exp_rdata[0] = 8'd0;
        run_txn(0, 0, 1'b0, 1'b0, "reset_mid_read");
        idle_cycle(0, "reset_mid_read");
    endtask

    task automatic test_step1();
        r_req[1] = 1'b1; r_addr[1] = 8'h55;
        run_txn(1, 0, 1'b0, 1'b1, "step1_a");
        idle_cycle(1, "step1_block");
        run_txn(1, 0, 1'b0, 1'b0, "step1_b");
        idle_cycle(1, "step1_end");
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            w_req[0]  = 1'($urandom % 2);
            r_req[0]  = w_req[0] ? 1'($urandom % 2) : 1'b1;
            w_addr[0] = 8'($urandom);
            w_data[0] = 8'($urandom);
            r_addr[0] = 8'($urandom);
            run_txn(0, 0, 1'($urandom % 2), 1'($urandom % 2), "random");
            idle_cycle(0, "random");
        end
        w_req[0] = 1'b0; r_req[0] = 1'b0;
    endtask

    initial begin
        steps[0] = S0;
        steps[1] = S1;
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_input_change();
        test_req_drop();
        test_reset_mid();
        test_step1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
